// File: rtl/inst_queue_pkg.sv
// Shared definitions for the instruction queue: pointer sizing helper,
// CPU-wide sizing parameters and the fetch packet type stored per entry.
package inst_queue_pkg;
   // Pointer width: index bits plus one wrap bit.
   function automatic int unsigned iq_ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

package cpu_params;
   localparam int IQ_DEPTH = 16;
endpackage

package uop_types;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_packet_t;
endpackage

// File: rtl/inst_queue_if.sv
// Dequeue-side handshake between the instruction queue and the backend.
interface fifo_backend_itf;
   logic        deq_valid;
   logic        deq_ready;
   logic [31:0] deq_pc;
   logic [31:0] deq_inst;

   modport fifo (
      output deq_valid,
      output deq_pc,
      output deq_inst,
      input  deq_ready
   );

   modport backend (
      input  deq_valid,
      input  deq_pc,
      input  deq_inst,
      output deq_ready
   );
endinterface

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and backend; head/tail carry a
// wrap bit so full and empty are told apart without a separate flag.
module inst_queue
   import inst_queue_pkg::*;
   import uop_types::*;
#(
   parameter int IQ_DEPTH = cpu_params::IQ_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         backend_flush,
   input  logic                         enq_valid,
   output logic                         enq_ready,
   input  logic [31:0]                  enq_pc,
   input  logic [31:0]                  enq_inst,
   fifo_backend_itf.fifo                to_backend,
   output logic [$clog2(IQ_DEPTH):0]    count
);

   localparam int PTR_W = int'(iq_ptr_w(IQ_DEPTH));
   localparam int IDX_W = PTR_W - 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] r_head;
   logic [PTR_W-1:0] r_tail;
   logic [PTR_W-1:0] r_count;

   fetch_packet_t r_mem [IQ_DEPTH];

   logic             w_empty;
   logic             w_full;
   logic             w_deq_valid;
   logic             w_enq;
   logic             w_deq;
   logic [IDX_W-1:0] w_head_idx;
   logic [IDX_W-1:0] w_tail_idx;
   logic [PTR_W-1:0] w_head_next;
   logic [PTR_W-1:0] w_tail_next;
   fetch_packet_t    w_head_entry;

   assign w_head_idx = r_head[IDX_W-1:0];
   assign w_tail_idx = r_tail[IDX_W-1:0];

   assign w_empty = (r_head == r_tail);
   assign w_full  = (w_head_idx == w_tail_idx) && (r_head[PTR_W-1] != r_tail[PTR_W-1]);

   // enq_ready depends on registered pointers only, never on deq_ready.
   assign enq_ready   = !w_full;
   assign w_deq_valid = !w_empty && !backend_flush;

   assign w_enq = enq_valid && !w_full && !backend_flush && !rst;
   assign w_deq = w_deq_valid && to_backend.deq_ready;

   assign w_head_next = w_deq ? (r_head + PTR_ONE) : r_head;
   assign w_tail_next = w_enq ? (r_tail + PTR_ONE) : r_tail;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (backend_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= w_head_next;
         r_tail  <= w_tail_next;
         r_count <= w_tail_next - w_head_next;
      end
   end

   // Entry storage is only ever written by an accepted enqueue.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[w_tail_idx] <= '{pc: enq_pc, inst: enq_inst};
      end
   end

   assign w_head_entry = r_mem[w_head_idx];

   assign to_backend.deq_valid = w_deq_valid;
   assign to_backend.deq_pc    = w_head_entry.pc;
   assign to_backend.deq_inst  = w_head_entry.inst;
   assign count                = r_count;

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 16, meaning number of entries (power of two, >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port backend_flush  input  1  backend mispredict or redirect; discard all queued entries.
REQ-005 SHALL have port enq_valid  input  1  fetch offers one instruction.
REQ-006 SHALL have port enq_ready  output  1  queue accepts an instruction this cycle.
REQ-007 SHALL have port enq_pc  input  32  PC of the offered instruction.
REQ-008 SHALL have port enq_inst  input  32  raw instruction word.
REQ-009 SHALL have port to_backend  fifo_backend_itf.fifo modport  -  carries deq_valid (out, 1), deq_ready (in, 1), deq_pc (out, 32), deq_inst (out, 32).
REQ-010 SHALL have port count  output  $clog2(IQ_DEPTH)+1  current number of valid entries.

Function
REQ-011 SHALL implement a circular buffer with head and tail pointers, each $clog2(IQ_DEPTH)+1 bits wide (index plus wrap bit).
REQ-012 SHALL signal empty when head equals tail in all bits.
REQ-013 SHALL signal full when the indices are equal and the wrap bits differ.
REQ-014 SHALL drive enq_ready = !full, derived from registered state only, with no combinational path from deq_ready.
REQ-015 SHALL drive deq_valid = !empty && !backend_flush.
REQ-016 SHALL drive deq_pc and deq_inst from the head entry whenever deq_valid is 1; their values are don't-care otherwise.
REQ-017 SHALL perform an enqueue when enq_valid && enq_ready && !backend_flush: write the entry at the tail index, then increment tail modulo 2*IQ_DEPTH.
REQ-018 SHALL perform a dequeue when deq_valid && deq_ready: increment head modulo 2*IQ_DEPTH.
REQ-019 SHALL have 1-cycle enqueue-to-dequeue latency; no same-cycle bypass from enq to deq, even when empty.
REQ-020 SHALL allow a simultaneous enqueue and dequeue in one cycle; count is unchanged.
REQ-021 SHALL reject enqueue when full, even if a dequeue occurs in the same cycle.
REQ-022 SHALL, on backend_flush=1, set head=tail=0 at the next edge; any enqueue or dequeue in that cycle is discarded.
REQ-023 SHALL give flush precedence over both the enq and the deq handshake in the same cycle.
REQ-024 SHALL compute count as tail minus head, modulo 2*IQ_DEPTH, and register it consistently with the pointers.
REQ-025 SHALL hold entry storage unchanged except on an enqueue write; storage needs no reset.
REQ-026 SHALL preserve FIFO order exactly across pointer wrap-around.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, set head=0 and tail=0, giving count=0, enq_ready=1, deq_valid=0.
REQ-028 SHALL give rst priority over backend_flush and over all handshakes.
REQ-029 SHALL lose all in-flight entries on a mid-operation reset, with no stale entry becoming visible after reset.

Structure
REQ-030 SHALL take IQ_DEPTH from the cpu_params package.
REQ-031 SHALL store entries as fetch_packet_t {pc[31:0], inst[31:0]}, defined in uop_types.
REQ-032 SHALL be a single flat module with no sub-modules; pointer logic is inline.

Verification
REQ-033 SHALL cover fill: with deq_ready=0, enqueue 16 instrs with pc 0x1000 to 0x103C -> enq_ready=0 after the 16th, count=16, the 17th is not accepted.
REQ-034 SHALL cover drain: from full, deq_ready=1 for 16 cycles -> deq_pc sequence 0x1000, 0x1004, ..., 0x103C, then deq_valid=0 and count=0.
REQ-035 SHALL cover wrap: 40 enqueues/dequeues interleaved randomly, deq_ready 50% -> output order identical to input, no loss or duplication.
REQ-036 SHALL cover flush: 5 entries queued, backend_flush=1 with enq_valid=1 and deq_ready=1 -> deq_valid=0 in that cycle, count=0 next cycle, the enqueued instr is dropped.
REQ-037 SHALL cover same-cycle enq+deq: count=3 with enq and deq both handshaking -> count stays 3 and the new entry appears 3 dequeues later.
REQ-038 SHALL cover reset mid-fill: 7 entries queued, rst=1 for 1 cycle -> count=0, enq_ready=1, deq_valid=0 on the next cycle.
